sodor5_lockstep_harness: RTL and testbench
==========================================

// Module: sodor5_lockstep_harness
// PURPOSE
//  Lockstep verification harness for RV32I I-type ALU instructions. One instruction
//  stream feeds two engines each cycle:
//   - s5m: a single-cycle ISA reference model.
//   - coretop: a 5-stage pipelined core (F/D/X/M/W) with full forwarding.
//  Retired writebacks of the two engines are compared. A sticky flag reports any
//  divergence. The block is the top of the sodor5 equivalence-check bench.
// PARAMETERS
//  NUM_REGS   32  architectural registers per engine
//  WORD_SIZE  32  datapath/register width in bits
// PORTS
//  clk           in   1   single clock; all state updates on posedge
//  reset         in   1   synchronous, active-high reset
//  instr         in   32  instruction word, one accepted every cycle while reset=0
//  mismatch      out  1   sticky; 1 once any retired writeback differs
//  retire_count  out  32  number of instructions retired by the pipeline
// BEHAVIOUR
//  Interface: one clock (clk); synchronous, active-high reset (reset).
//  Decode and execution
//  - Only opcode 7'b0010011 is executed: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI,
//    SRLI, SRAI. Any other opcode is a NOP (no register write).
//  - imm = sign-extended instr[31:20].
//  - Shifts use shamt = instr[24:20]. funct3=5 with instr[30]=1 is SRAI, else SRLI.
//  - SLTI is a signed compare and SLTIU an unsigned compare against the sign-extended
//    imm. Both give result 0/1.
//  - All arithmetic wraps modulo 2^32.
//  Register files
//  - Each engine has its own register file: s5m.regfile[0:31] and the core regfile.
//    Both are plain reg arrays, reachable hierarchically so the bench can preload them.
//  - Reset does NOT clear either register file.
//  - Reads of x0 return 0 regardless of stored contents. Writes to rd=0 are dropped
//    and are not counted as writebacks.
//  Reference model
//  - At the posedge where instr is sampled (reset=0), the model reads rs1, computes,
//    and writes rd in the same edge.
//  - Each sample pushes a record {valid, rd, data} into a 4-deep delay line.
//  Pipeline
//  - Edge k: instr captured in the D register.
//  - D reads operands. Forwarding priority is X > M > W, then the register file.
//  - Edges k+1, k+2, k+3: instruction moves to X, M, W.
//  - Edge k+4: register file written. Latency is 4 cycles, throughput 1 per cycle.
//  - The pipeline never stalls and never flushes.
//  Checker
//  - Every cycle, the W-stage record is compared combinationally with the delay-line
//    output. Compared fields: valid, and when valid, rd and data.
//  - Any difference sets mismatch at the next edge. mismatch stays 1 until reset.
//  - retire_count increments on each valid W-stage instruction, NOPs included. It
//    wraps at 2^32.
//  Reset (synchronous)
//  - Clears all pipeline valid bits and delay-line valids, mismatch (0) and
//    retire_count (0).
//  - instr is ignored while reset=1.
//  - Reset mid-operation discards in-flight instructions: no write, no compare.
//    Writes the model already performed are kept.
//  Simultaneous events
//  - W writes rd while D reads the same rd: D gets the forwarded value, not the
//    stale register file value.
// TESTING
//  1. x1=5; ADDI x2,x1,3 -> both x2=8 at edge+4, mismatch=0, retire_count=1.
//  2. ADDI x1,x0,1 then ADDI x1,x1,1 three times back-to-back -> x1=4 in both
//     engines, mismatch=0 (forwarding from X, M and W exercised).
//  3. x3=0x80000000; SRAI x4,x3,4 -> 0xF8000000; SRLI x5,x3,4 -> 0x08000000;
//     SLLI x6,x3,1 -> 0.
//  4. x1=1; SLTIU x7,x1,-1 -> 1; SLTI x8,x1,-1 -> 0; ADDI x0,x1,9 -> x0 reads 0,
//     no mismatch.
//  5. Force one core register-file entry to a wrong value, then read it -> mismatch=1
//     and stays 1 until reset.
//  6. Assert reset with 3 instructions in flight -> no pipeline write, retire_count=0,
//     mismatch=0; regfiles otherwise preserved.

Source files
------------

// File: rtl/sodor5_lockstep_harness.sv
// Lockstep harness: a single-cycle reference engine and a 5-stage pipelined core
// execute the same RV32I I-type ALU stream; their retired writebacks are cross-checked.

module sodor5_alu #(
  parameter int WORD_SIZE = 32
) (
  input  logic [11:0]          imm12,
  input  logic [2:0]           funct3,
  input  logic [4:0]           rd,
  input  logic [6:0]           opcode,
  input  logic [WORD_SIZE-1:0] src,
  output logic [WORD_SIZE-1:0] result,
  output logic                 wen
);
  logic [WORD_SIZE-1:0] imm;
  logic [4:0]           shamt;

  always_comb begin
    imm    = {{(WORD_SIZE-12){imm12[11]}}, imm12};
    shamt  = imm12[4:0];
    result = '0;
    case (funct3)
      3'd0: result = src + imm;
      3'd1: result = src << shamt;
      3'd2: result = {{(WORD_SIZE-1){1'b0}}, $signed(src) < $signed(imm)};
      3'd3: result = {{(WORD_SIZE-1){1'b0}}, src < imm};
      3'd4: result = src ^ imm;
      3'd5: begin
        // imm12[10] is instr[30]: selects arithmetic over logical right shift
        if (imm12[10]) result = $signed(src) >>> shamt;
        else           result = src >> shamt;
      end
      3'd6: result = src | imm;
      3'd7: result = src & imm;
      default: result = '0;
    endcase
    wen = (opcode == 7'b0010011) && (rd != 5'd0);
  end
endmodule

module sodor5_s5m #(
  parameter int NUM_REGS  = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  output logic                 ref_valid,
  output logic [4:0]           ref_rd,
  output logic [WORD_SIZE-1:0] ref_data
);
  localparam int DEPTH = 4;

  logic [WORD_SIZE-1:0] regfile [0:NUM_REGS-1];
  logic [4:0]           rs1;
  logic [4:0]           rd;
  logic [WORD_SIZE-1:0] src;
  logic [WORD_SIZE-1:0] result;
  logic                 wen;

  logic                 dl_valid_reg [0:DEPTH-1];
  logic [4:0]           dl_rd_reg    [0:DEPTH-1];
  logic [WORD_SIZE-1:0] dl_data_reg  [0:DEPTH-1];

  assign rs1 = instr[19:15];
  assign rd  = instr[11:7];
  assign src = (rs1 == 5'd0) ? '0 : regfile[rs1];

  sodor5_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .imm12  (instr[31:20]),
    .funct3 (instr[14:12]),
    .rd     (rd),
    .opcode (instr[6:0]),
    .src    (src),
    .result (result),
    .wen    (wen)
  );

  always_ff @(posedge clk) begin
    if (!reset && wen) regfile[rd] <= result;
  end

  // Delay line aligns each reference writeback with the core's W stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) dl_valid_reg[i] <= 1'b0;
    end else begin
      dl_valid_reg[0] <= wen;
      for (int i = 1; i < DEPTH; i++) dl_valid_reg[i] <= dl_valid_reg[i-1];
    end
    dl_rd_reg[0]   <= rd;
    dl_data_reg[0] <= result;
    for (int i = 1; i < DEPTH; i++) begin
      dl_rd_reg[i]   <= dl_rd_reg[i-1];
      dl_data_reg[i] <= dl_data_reg[i-1];
    end
  end

  assign ref_valid = dl_valid_reg[DEPTH-1];
  assign ref_rd    = dl_rd_reg[DEPTH-1];
  assign ref_data  = dl_data_reg[DEPTH-1];
endmodule

module sodor5_coretop #(
  parameter int NUM_REGS  = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr,
  output logic                 w_valid,
  output logic                 w_we,
  output logic [4:0]           w_rd,
  output logic [WORD_SIZE-1:0] w_data
);
  logic [WORD_SIZE-1:0] regfile [0:NUM_REGS-1];

  logic                 d_valid_reg;
  logic [31:0]          d_instr_reg;
  logic                 x_valid_reg;
  logic [11:0]          x_imm_reg;
  logic [2:0]           x_f3_reg;
  logic [4:0]           x_rd_reg;
  logic [6:0]           x_op_reg;
  logic [WORD_SIZE-1:0] x_src_reg;
  logic                 m_valid_reg;
  logic                 m_we_reg;
  logic [4:0]           m_rd_reg;
  logic [WORD_SIZE-1:0] m_data_reg;
  logic                 w_valid_reg;
  logic                 w_we_reg;
  logic [4:0]           w_rd_reg;
  logic [WORD_SIZE-1:0] w_data_reg;

  logic [4:0]           d_rs1;
  logic [WORD_SIZE-1:0] d_src;
  logic [WORD_SIZE-1:0] x_result;
  logic                 x_alu_wen;
  logic                 x_we;

  sodor5_alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .imm12  (x_imm_reg),
    .funct3 (x_f3_reg),
    .rd     (x_rd_reg),
    .opcode (x_op_reg),
    .src    (x_src_reg),
    .result (x_result),
    .wen    (x_alu_wen)
  );

  assign x_we  = x_valid_reg && x_alu_wen;
  assign d_rs1 = d_instr_reg[19:15];

  // Operand fetch: youngest in-flight producer wins, the W bypass also
  // covers the cycle in which W is writing the register file.
  always_comb begin
    d_src = regfile[d_rs1];
    if (d_rs1 == 5'd0)                             d_src = '0;
    else if (x_we && (x_rd_reg == d_rs1))          d_src = x_result;
    else if (m_we_reg && (m_rd_reg == d_rs1))      d_src = m_data_reg;
    else if (w_we_reg && (w_rd_reg == d_rs1))      d_src = w_data_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_valid_reg <= 1'b0;
      x_valid_reg <= 1'b0;
      m_valid_reg <= 1'b0;
      m_we_reg    <= 1'b0;
      w_valid_reg <= 1'b0;
      w_we_reg    <= 1'b0;
    end else begin
      d_valid_reg <= 1'b1;
      x_valid_reg <= d_valid_reg;
      m_valid_reg <= x_valid_reg;
      m_we_reg    <= x_we;
      w_valid_reg <= m_valid_reg;
      w_we_reg    <= m_we_reg;
    end
    d_instr_reg <= instr;
    x_imm_reg   <= d_instr_reg[31:20];
    x_f3_reg    <= d_instr_reg[14:12];
    x_rd_reg    <= d_instr_reg[11:7];
    x_op_reg    <= d_instr_reg[6:0];
    x_src_reg   <= d_src;
    m_rd_reg    <= x_rd_reg;
    m_data_reg  <= x_result;
    w_rd_reg    <= m_rd_reg;
    w_data_reg  <= m_data_reg;
  end

  always_ff @(posedge clk) begin
    if (!reset && w_we_reg) regfile[w_rd_reg] <= w_data_reg;
  end

  assign w_valid = w_valid_reg;
  assign w_we    = w_we_reg;
  assign w_rd    = w_rd_reg;
  assign w_data  = w_data_reg;
endmodule

module sodor5_lockstep_harness #(
  parameter int NUM_REGS  = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        mismatch,
  output logic [31:0] retire_count
);
  logic                 ref_valid;
  logic [4:0]           ref_rd;
  logic [WORD_SIZE-1:0] ref_data;
  logic                 w_valid;
  logic                 w_we;
  logic [4:0]           w_rd;
  logic [WORD_SIZE-1:0] w_data;
  logic                 diff;
  logic                 mismatch_reg;
  logic [31:0]          retire_count_reg;

  sodor5_s5m #(.NUM_REGS(NUM_REGS), .WORD_SIZE(WORD_SIZE)) s5m (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .ref_valid (ref_valid),
    .ref_rd    (ref_rd),
    .ref_data  (ref_data)
  );

  sodor5_coretop #(.NUM_REGS(NUM_REGS), .WORD_SIZE(WORD_SIZE)) coretop (
    .clk     (clk),
    .reset   (reset),
    .instr   (instr),
    .w_valid (w_valid),
    .w_we    (w_we),
    .w_rd    (w_rd),
    .w_data  (w_data)
  );

  assign diff = (w_we != ref_valid) ||
                (w_we && ((w_rd != ref_rd) || (w_data != ref_data)));

  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_reg     <= 1'b0;
      retire_count_reg <= '0;
    end else begin
      if (diff)    mismatch_reg     <= 1'b1;
      if (w_valid) retire_count_reg <= retire_count_reg + 32'd1;
    end
  end

  assign mismatch     = mismatch_reg;
  assign retire_count = retire_count_reg;
endmodule

// File: tb/tb_sodor5_lockstep_harness.sv
// Bench for the sodor5 lockstep harness: directed table, hand sequences for
// corruption and mid-flight reset, then random I-type streams against a model.
module tb_sodor5_lockstep_harness;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        mismatch;
  logic [31:0] retire_count;

  int          n_vec = 0;
  int          n_miss = 0;
  int          acc = 0;
  logic        exp_mm = 1'b0;
  logic [31:0] arch [32];
  logic [31:0] pre [3];

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] value;
  } vec_t;
  vec_t tbl [$];

  always #5 clk = ~clk;

  sodor5_lockstep_harness dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .mismatch     (mismatch),
    .retire_count (retire_count)
  );

  function automatic logic [31:0] itype(input int imm, input int rs1, input int f3, input int rd);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'h13};
  endfunction

  // Architectural result of one I-type ALU instruction given the rs1 value.
  function automatic logic [31:0] golden(input logic [31:0] i, input logic [31:0] a);
    logic [31:0] imm;
    int          sh;
    imm = {{20{i[31]}}, i[31:20]};
    sh  = int'(i[24:20]);
    case (i[14:12])
      3'd0: return a + imm;
      3'd1: return a << sh;
      3'd2: return (int'(a) < int'(imm)) ? 32'd1 : 32'd0;
      3'd3: return (a < imm) ? 32'd1 : 32'd0;
      3'd4: return a ^ imm;
      3'd5: return (i[30] && a[31]) ? ~((~a) >> sh) : (a >> sh);
      3'd6: return a | imm;
      default: return a & imm;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] i);
    logic [31:0] a;
    logic [4:0]  rd;
    rd = i[11:7];
    a  = (i[19:15] == 5'd0) ? 32'h0 : arch[i[19:15]];
    instr = i;
    @(negedge clk);
    acc++;
    $display("txn %0d instr=%08h mismatch=%0b retire=%0d", acc, i, mismatch, retire_count);
    if (i[6:0] == 7'h13 && rd != 5'd0) begin
      arch[rd] = golden(i, a);
      check($sformatf("s5m_x%0d", rd), dut.s5m.regfile[rd], arch[rd]);
    end
    check("mismatch", {31'b0, mismatch}, {31'b0, exp_mm});
    check("retire_count", retire_count, (acc > 4) ? 32'(acc - 4) : 32'd0);
  endtask

  task automatic drain();
    repeat (5) issue(32'h0);
  endtask

  task automatic check_core();
    for (int r = 1; r < 32; r++)
      check($sformatf("core_x%0d", r), dut.coretop.regfile[r], arch[r]);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    instr = $urandom;
    @(negedge clk);
    reset  = 1'b0;
    acc    = 0;
    exp_mm = 1'b0;
    check("reset_mismatch", {31'b0, mismatch}, 32'd0);
    check("reset_retire", retire_count, 32'd0);
  endtask

  initial begin
    tbl.push_back('{itype(5, 0, 0, 1),        5'd1,  32'd5});
    tbl.push_back('{itype(3, 1, 0, 2),        5'd2,  32'd8});
    tbl.push_back('{itype(1, 0, 0, 1),        5'd1,  32'd1});
    tbl.push_back('{itype(1, 1, 0, 1),        5'd1,  32'd2});
    tbl.push_back('{itype(1, 1, 0, 1),        5'd1,  32'd3});
    tbl.push_back('{itype(1, 1, 0, 1),        5'd1,  32'd4});
    tbl.push_back('{itype(1, 0, 0, 3),        5'd3,  32'd1});
    tbl.push_back('{itype(31, 3, 1, 3),       5'd3,  32'h80000000});
    tbl.push_back('{itype('h404, 3, 5, 4),    5'd4,  32'hF8000000});
    tbl.push_back('{itype(4, 3, 5, 5),        5'd5,  32'h08000000});
    tbl.push_back('{itype(1, 3, 1, 6),        5'd6,  32'h0});
    tbl.push_back('{itype(1, 0, 0, 1),        5'd1,  32'd1});
    tbl.push_back('{itype(-1, 1, 3, 7),       5'd7,  32'd1});
    tbl.push_back('{itype(-1, 1, 2, 8),       5'd8,  32'd0});
    tbl.push_back('{itype(9, 1, 0, 0),        5'd0,  32'hDEADBEEF});
    tbl.push_back('{itype(0, 0, 0, 9),        5'd9,  32'h0});
    tbl.push_back('{itype(-1, 3, 4, 10),      5'd10, 32'h7FFFFFFF});
    tbl.push_back('{itype('hF0, 1, 6, 11),    5'd11, 32'h000000F1});
    tbl.push_back('{itype('h7F0, 10, 7, 12),  5'd12, 32'h000007F0});
    tbl.push_back('{itype(5, 1, 0, 12) ^ 32'h20, 5'd12, 32'h000007F0});
    tbl.push_back('{itype(-2048, 12, 0, 13),  5'd13, 32'hFFFFFFF0});
    tbl.push_back('{itype('h402, 13, 5, 14),  5'd14, 32'hFFFFFFFC});

    repeat (3) @(negedge clk);
    dut.s5m.regfile[0]     = 32'hDEADBEEF;
    dut.coretop.regfile[0] = 32'hDEADBEEF;
    arch[0] = 32'h0;
    for (int r = 1; r < 32; r++) begin
      arch[r] = $urandom;
      dut.s5m.regfile[r]     = arch[r];
      dut.coretop.regfile[r] = arch[r];
    end
    check("reset_mismatch", {31'b0, mismatch}, 32'd0);
    check("reset_retire", retire_count, 32'd0);
    reset = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      issue(tbl[k].instr);
      check($sformatf("tbl%0d_x%0d", k, tbl[k].rd), dut.s5m.regfile[tbl[k].rd], tbl[k].value);
    end
    drain();
    check_core();

    // Corrupt one core register, read it, and expect a sticky divergence.
    dut.coretop.regfile[5] = arch[5] ^ 32'h1;
    issue(itype(0, 5, 0, 20));
    repeat (3) issue(32'h0);
    exp_mm = 1'b1;
    repeat (4) issue(32'h0);
    pulse_reset();
    dut.coretop.regfile[5]  = arch[5];
    dut.coretop.regfile[20] = arch[20];

    // Reset with three writers in flight: the core must not commit them.
    for (int r = 0; r < 3; r++) pre[r] = arch[21 + r];
    issue(itype('h111, 0, 0, 21));
    issue(itype(1, 21, 0, 22));
    issue(itype(1, 22, 0, 23));
    pulse_reset();
    drain();
    for (int r = 0; r < 3; r++) begin
      check($sformatf("flushed_core_x%0d", 21 + r), dut.coretop.regfile[21 + r], pre[r]);
      check($sformatf("kept_s5m_x%0d", 21 + r), dut.s5m.regfile[21 + r], arch[21 + r]);
      dut.coretop.regfile[21 + r] = arch[21 + r];
    end

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0)
        issue($urandom);
      else
        issue(itype(int'($urandom), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
    end
    drain();
    check_core();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
